thiele_adjacency_loader: RTL and testbench

//   Upstream feeder for thiele_autonomous_solver. Accepts a graph one adjacency row per valid/ready beat and

---
 rtl/thiele_adjacency_loader.sv | 146 ++++++++++++++
 tb/tb_thiele_adjacency_loader.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/thiele_adjacency_loader.sv
// Collects NODES adjacency rows, validates the graph (self-loops, asymmetry), counts edges,
// launches the solver with a stable adjacency bus and holds one result record until acknowledged.
module thiele_adjacency_loader #(
  parameter int NODES          = 9,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     row_valid,
  output logic                     row_ready,
  input  logic [NODES-1:0]         row_data,
  output logic [NODES*NODES-1:0]   adjacency,
  output logic                     solver_start,
  input  logic                     solver_done,
  input  logic                     solver_success,
  output logic                     busy,
  output logic                     result_valid,
  input  logic                     result_ack,
  output logic                     result_success,
  output logic [1:0]               error_code,
  output logic [7:0]               error_row,
  output logic [15:0]              edge_count
);
  localparam int IW   = (NODES > 1) ? $clog2(NODES) : 1;
  localparam int CW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SUMW = $clog2(NODES * NODES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CHECK, S_LAUNCH, S_WAIT, S_RESULT
  } state_t;

  state_t                   r_state, w_next;
  logic                     r_armed;
  logic [IW-1:0]            r_idx;
  logic [NODES*NODES-1:0]   r_adj;
  logic [SUMW-1:0]          r_sum;
  logic [1:0]               r_err;
  logic [7:0]               r_err_row;
  logic [15:0]              r_edges;
  logic                     r_succ;
  logic                     r_start;
  logic [CW-1:0]            r_tmo;

  logic [NODES-1:0]         w_row, w_col;
  logic [SUMW-1:0]          w_pop;
  logic                     w_self, w_asym, w_chk_err, w_accept, w_timeout, w_last;

  // r_idx walks rows both while loading and while checking
  always_comb begin
    w_row = r_adj[int'(r_idx)*NODES +: NODES];
    w_col = '0;
    w_pop = '0;
    for (int j = 0; j < NODES; j++) begin
      w_col[j] = r_adj[j*NODES + int'(r_idx)];
      w_pop    = w_pop + SUMW'(w_row[j]);
    end
    w_self    = w_row[r_idx];
    w_asym    = (w_row != w_col);
    w_chk_err = w_self || w_asym;
  end

  assign row_ready = r_armed && ((r_state == S_IDLE) || (r_state == S_LOAD));
  assign w_accept  = row_valid && row_ready;
  assign w_last    = (r_idx == IW'(NODES - 1));
  assign w_timeout = (r_tmo == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_next = (w_last) ? S_CHECK : S_LOAD;
      S_LOAD:   if (w_accept && w_last) w_next = S_CHECK;
      S_CHECK:  if (w_last) w_next = ((r_err != 2'd0) || w_chk_err) ? S_RESULT : S_LAUNCH;
      S_LAUNCH: w_next = S_WAIT;
      S_WAIT:   if (solver_done || w_timeout) w_next = S_RESULT;
      S_RESULT: if (result_ack) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_armed   <= 1'b0;
      r_idx     <= '0;
      r_adj     <= '0;
      r_sum     <= '0;
      r_err     <= 2'd0;
      r_err_row <= 8'd0;
      r_edges   <= 16'd0;
      r_succ    <= 1'b0;
      r_start   <= 1'b0;
      r_tmo     <= '0;
    end else begin
      r_state <= w_next;
      r_armed <= 1'b1;
      // registered so the solver never sees a decode glitch on start
      r_start <= (w_next == S_LAUNCH);
      case (r_state)
        S_IDLE, S_LOAD: begin
          if (w_accept) begin
            r_adj[int'(r_idx)*NODES +: NODES] <= row_data;
            r_idx <= w_last ? '0 : r_idx + IW'(1);
            if (w_last) r_sum <= '0;
          end
        end
        S_CHECK: begin
          r_sum <= r_sum + w_pop;
          r_idx <= w_last ? '0 : r_idx + IW'(1);
          if ((r_err == 2'd0) && w_chk_err) begin
            r_err     <= w_self ? 2'd1 : 2'd2;
            r_err_row <= 8'(r_idx);
          end
          if (w_last) r_edges <= 16'((r_sum + w_pop) >> 1);
        end
        S_LAUNCH: r_tmo <= '0;
        S_WAIT: begin
          if (solver_done) begin
            r_succ <= solver_success;
          end else if (w_timeout) begin
            r_err     <= 2'd3;
            r_err_row <= 8'd0;
          end else begin
            r_tmo <= r_tmo + CW'(1);
          end
        end
        S_RESULT: begin
          if (result_ack) begin
            r_err     <= 2'd0;
            r_err_row <= 8'd0;
            r_succ    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign adjacency      = r_adj;
  assign solver_start   = r_start;
  assign busy           = (r_state != S_IDLE);
  assign result_valid   = (r_state == S_RESULT);
  assign result_success = r_succ;
  assign error_code     = r_err;
  assign error_row      = r_err_row;
  assign edge_count     = r_edges;
endmodule

// File: tb/tb_thiele_adjacency_loader.sv
// Bench for thiele_adjacency_loader: directed vector table, corner sequences, random graphs vs reference model.
module tb_thiele_adjacency_loader;
  localparam int NODES = 9;
  localparam int TO    = 20;
  localparam int AW    = NODES * NODES;
  typedef logic [AW-1:0] adj_t;
  typedef struct {
    adj_t        adj;
    logic [1:0]  err;
    logic [7:0]  row;
    logic [15:0] edges;
  } vec_t;

  localparam adj_t BASE = {9'h018, 9'h028, 9'h030, 9'h0C3, 9'h145, 9'h186, 9'h01B, 9'h02D, 9'h036};
  localparam adj_t K9   = {9'h0FF, 9'h17F, 9'h1BF, 9'h1DF, 9'h1EF, 9'h1F7, 9'h1FB, 9'h1FD, 9'h1FE};

  logic             clk = 1'b0;
  logic             reset_n;
  logic             row_valid;
  logic             row_ready;
  logic [NODES-1:0] row_data;
  adj_t             adjacency;
  logic             solver_start;
  logic             solver_done;
  logic             solver_success;
  logic             busy;
  logic             result_valid;
  logic             result_ack;
  logic             result_success;
  logic [1:0]       error_code;
  logic [7:0]       error_row;
  logic [15:0]      edge_count;

  int checks    = 0;
  int errors    = 0;
  int start_cnt = 0;

  thiele_adjacency_loader #(.NODES(NODES), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n), .row_valid(row_valid), .row_ready(row_ready),
    .row_data(row_data), .adjacency(adjacency), .solver_start(solver_start),
    .solver_done(solver_done), .solver_success(solver_success), .busy(busy),
    .result_valid(result_valid), .result_ack(result_ack), .result_success(result_success),
    .error_code(error_code), .error_row(error_row), .edge_count(edge_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (solver_start) start_cnt <= start_cnt + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_outs"}, {row_ready, solver_start, busy, result_valid, result_success,
                          error_code, error_row, edge_count}, '0);
    check({tag, "_adj"}, adjacency, '0);
  endtask

  // Reference: first offending row wins, self-loop before asymmetry; edges = popcount/2
  function automatic void model(input adj_t g, output logic [1:0] err, output logic [7:0] row,
                                output logic [15:0] edges);
    err = 2'd0;
    row = 8'd0;
    for (int r = 0; r < NODES; r++) begin
      if (err == 2'd0) begin
        if (g[r*NODES + r]) begin
          err = 2'd1; row = 8'(r);
        end else begin
          for (int j = 0; j < NODES; j++)
            if (g[r*NODES + j] != g[j*NODES + r]) begin err = 2'd2; row = 8'(r); end
        end
      end
    end
    edges = 16'($countones(g) / 2);
  endfunction

  task automatic load_rows(input adj_t g, input int gap_max, input int nrows);
    int gap, w;
    for (int r = 0; r < nrows; r++) begin
      gap = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      for (int k = 0; k < gap; k++) begin
        row_data = NODES'($urandom);
        tick();
      end
      row_valid = 1'b1;
      row_data  = g[r*NODES +: NODES];
      w = 0;
      while (!row_ready && w < 50) begin tick(); w++; end
      check("row_ready", row_ready, 1'b1);
      tick();
      row_valid = 1'b0;
    end
  endtask

  task automatic run_case(input adj_t g, input int gap_max, input int done_dly, input bit succ,
                          input int ack_dly, input bit done_in_launch, input logic [1:0] exp_err,
                          input logic [7:0] exp_row, input logic [15:0] exp_edges);
    int n, held, base_starts, exp_n;
    bit launched;
    launched    = (exp_err == 2'd0) || (exp_err == 2'd3);
    base_starts = start_cnt;
    load_rows(g, gap_max, NODES);
    n = 1;
    while (!solver_start && !result_valid && n < 40) begin tick(); n++; end
    check("launch_latency", n, NODES + 1);
    if (launched) begin
      check("start_seen", solver_start, 1'b1);
      check("adj_bus", adjacency, g);
      if (done_in_launch) begin solver_done = 1'b1; solver_success = 1'b1; end
      tick();
      solver_done = 1'b0;
      check("start_width", solver_start, 1'b0);
      n = 0;
      while (!result_valid && n < TO + 5) begin
        if (n == done_dly) begin solver_done = 1'b1; solver_success = succ; end
        tick();
        solver_done = 1'b0;
        n++;
      end
      exp_n = (done_dly >= 0 && done_dly < TO) ? done_dly + 1 : TO;
      check("result_latency", n, exp_n);
      check("adj_hold", adjacency, g);
    end
    check("result_valid", result_valid, 1'b1);
    held = 0;
    for (int k = 0; k < ack_dly; k++) begin
      tick();
      if (result_valid) held++;
    end
    check("result_hold", held, ack_dly);
    check("error_code", error_code, exp_err);
    check("error_row", error_row, exp_row);
    check("edge_count", edge_count, exp_edges);
    check("result_success", result_success, (exp_err == 2'd0) ? succ : 1'b0);
    check("start_pulses", start_cnt - base_starts, launched ? 1 : 0);
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0;
    check("ack_idle", {result_valid, busy, row_ready, error_code, error_row}, {1'b0, 1'b0, 1'b1, 2'd0, 8'd0});
    check("adj_keep", adjacency, g);
  endtask

  vec_t        vt [7];
  adj_t        g;
  logic [1:0]  m_err;
  logic [7:0]  m_row;
  logic [15:0] m_edges;
  int          dd, n;
  bit          sc;

  initial begin
    g = BASE;                  vt[0] = '{adj: g, err: 2'd0, row: 8'd0, edges: 16'd15};
    g[4*NODES +: NODES] = 9'h155; vt[1] = '{adj: g, err: 2'd1, row: 8'd4, edges: 16'd15};
    g = BASE; g[0 +: NODES] = 9'h037;          vt[2] = '{adj: g, err: 2'd1, row: 8'd0, edges: 16'd15};
    g = BASE; g[6*NODES +: NODES] = 9'h031;    vt[3] = '{adj: g, err: 2'd2, row: 8'd0, edges: 16'd15};
    g = K9;                                    vt[4] = '{adj: g, err: 2'd0, row: 8'd0, edges: 16'd36};
    g = '0; g[8*NODES + 7] = 1'b1;             vt[5] = '{adj: g, err: 2'd2, row: 8'd7, edges: 16'd0};
    g = '0; g[8*NODES + 8] = 1'b1;             vt[6] = '{adj: g, err: 2'd1, row: 8'd8, edges: 16'd0};

    reset_n = 1'b0; row_valid = 1'b0; row_data = '0;
    solver_done = 1'b0; solver_success = 1'b0; result_ack = 1'b0;
    #12;
    check_all_zero("reset");
    @(negedge clk); reset_n = 1'b1;
    tick();
    check("idle_ready", {row_ready, busy}, 2'b10);

    for (int i = 0; i < 7; i++)
      run_case(vt[i].adj, 0, 2, 1'b1, 1, 1'b0, vt[i].err, vt[i].row, vt[i].edges);

    // upstream gaps, late solver, consumer holds off the ack
    run_case(BASE, 3, 4, 1'b1, 7, 1'b0, 2'd0, 8'd0, 16'd15);
    // solver silent (early done in LAUNCH must be ignored) -> timeout
    run_case(BASE, 0, -1, 1'b1, 0, 1'b1, 2'd3, 8'd0, 16'd15);
    // done coincides with the timeout cycle -> done wins
    run_case(BASE, 0, TO - 1, 1'b1, 0, 1'b0, 2'd0, 8'd0, 16'd15);
    run_case(BASE, 0, 0, 1'b0, 2, 1'b0, 2'd0, 8'd0, 16'd15);

    // reset mid-LOAD
    load_rows(BASE, 0, 4);
    #2 reset_n = 1'b0;
    #1 check_all_zero("rst_load");
    @(negedge clk); reset_n = 1'b1;
    tick();
    run_case(BASE, 0, 1, 1'b1, 0, 1'b0, 2'd0, 8'd0, 16'd15);

    // reset mid-WAIT
    load_rows(BASE, 0, NODES);
    n = 0;
    while (!solver_start && n < 40) begin tick(); n++; end
    check("wait_start", solver_start, 1'b1);
    tick(); tick(); tick();
    check("wait_busy", busy, 1'b1);
    #2 reset_n = 1'b0;
    #1 check_all_zero("rst_wait");
    @(negedge clk); reset_n = 1'b1;
    tick();
    run_case(BASE, 0, 1, 1'b1, 0, 1'b0, 2'd0, 8'd0, 16'd15);

    for (int it = 0; it < 30; it++) begin
      g = '0;
      for (int i = 0; i < NODES; i++)
        for (int j = i + 1; j < NODES; j++)
          if ($urandom_range(2, 0) == 0) begin
            g[i*NODES + j] = 1'b1;
            g[j*NODES + i] = 1'b1;
          end
      if ($urandom_range(2, 0) == 0)
        g[$urandom_range(AW - 1, 0)] ^= 1'b1;
      model(g, m_err, m_row, m_edges);
      dd = int'($urandom_range(TO + 2, 0));
      sc = 1'($urandom);
      if (m_err == 2'd0 && dd >= TO) begin m_err = 2'd3; m_row = 8'd0; end
      run_case(g, int'($urandom_range(2, 0)), dd, sc, int'($urandom_range(3, 0)), 1'b0,
               m_err, m_row, m_edges);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
